// File: rtl/nn_stream_pkg.sv
// Shared types and default sizes for the input-layer streaming path.
package nn_stream_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam int unsigned DEF_DATA_W   = 8;
  localparam int unsigned DEF_N_INPUTS = 16;
  localparam int unsigned DEF_CNT_W    = $clog2(DEF_N_INPUTS + 1);

  // Width needed to count 0..n inclusive.
  function automatic int unsigned cnt_width(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with first-word-fall-through head and occupancy count.
module sync_fifo #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head,
  output logic [CNT_W-1:0]  count
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              do_push;
  logic              do_pop;

  // A push into a full buffer is accepted only when a pop frees a slot on the same edge.
  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count != CNT_W'(DEPTH)) || do_pop);

  // Head reads as zero while empty so the output is defined after reset.
  assign head = (count != '0) ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/nn_input_streamer.sv
// Streams one sample of N_INPUTS feature words from a synchronous-read ROM
// onto a valid/ready link, buffering ROM returns in a small FIFO.
module nn_input_streamer
  import nn_stream_pkg::*;
#(
  parameter int unsigned DATA_W     = DEF_DATA_W,
  parameter int unsigned N_INPUTS   = DEF_N_INPUTS,
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned BASE_ADDR  = 0,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              rom_en,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  localparam int unsigned CNT_W  = cnt_width(N_INPUTS);
  localparam int unsigned FCNT_W = $clog2(FIFO_DEPTH + 1);

  state_t            state;
  state_t            state_next;
  logic              busy_next;
  logic              done_next;
  logic              start_stream;
  logic [CNT_W-1:0]  issued;
  logic [CNT_W-1:0]  sent;
  logic              rd_pend;
  logic [FCNT_W-1:0] fifo_count;
  logic              issue;
  logic              pop;

  // Reads are throttled so buffered words plus the two pipeline stages never exceed the FIFO.
  assign issue = (state == STREAM)
              && (issued < CNT_W'(N_INPUTS))
              && ((32'(fifo_count) + 32'(rom_en) + 32'(rd_pend)) < FIFO_DEPTH);

  assign pop       = out_valid && out_ready;
  assign out_valid = (fifo_count != '0);
  assign out_last  = out_valid && (sent == CNT_W'(N_INPUTS - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next   = state;
    busy_next    = busy;
    done_next    = 1'b0;
    start_stream = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_next   = STREAM;
          busy_next    = 1'b1;
          start_stream = 1'b1;
        end
      end
      STREAM: begin
        if (pop && out_last) begin
          state_next = DONE;
          busy_next  = 1'b0;
          done_next  = 1'b1;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy     <= 1'b0;
      done     <= 1'b0;
      rom_en   <= 1'b0;
      rom_addr <= ADDR_W'(BASE_ADDR);
      rd_pend  <= 1'b0;
      issued   <= '0;
      sent     <= '0;
    end else begin
      busy    <= busy_next;
      done    <= done_next;
      rom_en  <= issue;
      rd_pend <= rom_en;
      if (issue) rom_addr <= ADDR_W'(BASE_ADDR) + ADDR_W'(issued);
      if (start_stream) begin
        issued <= '0;
        sent   <= '0;
      end else begin
        if (issue) issued <= issued + CNT_W'(1);
        if (pop)   sent   <= sent + CNT_W'(1);
      end
    end
  end

  // ROM data lands one cycle after rom_en is seen; rd_pend marks that cycle.
  sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (rd_pend),
    .push_data (rom_data),
    .pop       (pop),
    .head      (out_data),
    .count     (fifo_count)
  );

endmodule

// File: tb/tb_nn_input_streamer.sv
// Scoreboard bench for nn_input_streamer: a 16-word instance plus N=1 and
// wrapped-address N=4 instances.
module tb_nn_input_streamer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  logic rst;
  logic one = 1'b1;

  // Main instance: N_INPUTS=16, BASE_ADDR=0
  logic       start, out_ready, rom_en, out_valid, out_last, busy, done;
  logic [7:0] rom_addr, out_data;
  logic [7:0] rom_data = 8'h00;
  logic [7:0] rom [256];

  // N_INPUTS=1 instance
  logic       s1_start, s1_rom_en, s1_valid, s1_last, s1_busy, s1_done;
  logic [7:0] s1_addr, s1_data;
  logic [7:0] s1_rdata = 8'h00;

  // N_INPUTS=4, BASE_ADDR=FE instance
  logic       s4_start, s4_rom_en, s4_valid, s4_last, s4_busy, s4_done;
  logic [7:0] s4_addr, s4_data;
  logic [7:0] s4_rdata = 8'h00;

  nn_input_streamer #(.DATA_W(8), .N_INPUTS(16), .ADDR_W(8), .BASE_ADDR(0), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .start(start), .rom_en(rom_en), .rom_addr(rom_addr),
    .rom_data(rom_data), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .busy(busy), .done(done));

  nn_input_streamer #(.DATA_W(8), .N_INPUTS(1), .ADDR_W(8), .BASE_ADDR(0), .FIFO_DEPTH(4)) dut1 (
    .clk(clk), .rst(rst), .start(s1_start), .rom_en(s1_rom_en), .rom_addr(s1_addr),
    .rom_data(s1_rdata), .out_data(s1_data), .out_valid(s1_valid), .out_ready(one),
    .out_last(s1_last), .busy(s1_busy), .done(s1_done));

  nn_input_streamer #(.DATA_W(8), .N_INPUTS(4), .ADDR_W(8), .BASE_ADDR(8'hFE), .FIFO_DEPTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(s4_start), .rom_en(s4_rom_en), .rom_addr(s4_addr),
    .rom_data(s4_rdata), .out_data(s4_data), .out_valid(s4_valid), .out_ready(one),
    .out_last(s4_last), .busy(s4_busy), .done(s4_done));

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 8'(8'h10 + i);
  end

  // Synchronous-read ROM models
  always @(posedge clk) if (rom_en)    rom_data <= rom[rom_addr];
  always @(posedge clk) if (s1_rom_en) s1_rdata <= (s1_addr == 8'h00) ? 8'hA5 : 8'h00;
  always @(posedge clk) if (s4_rom_en) s4_rdata <= s4_addr ^ 8'h5A;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string nm);
    total++;
    bad++;
    $display("FAIL %s (cycle %0d)", nm, cyc);
  endtask

  // Scoreboard state: expected {last,data} words and expected done pulses
  logic [8:0] exp_q [$];
  int         done_pend = 0;
  int         reads = 0, hs = 0, sin = 0;
  logic       stall_prev = 1'b0;
  logic [8:0] stall_word;
  logic [8:0] e;

  // Monitor for the main instance
  always @(negedge clk) begin
    if (rst) begin
      reads = 0; hs = 0; sin = 0; stall_prev = 1'b0;
    end else begin
      if (!busy) sin = 0;
      if (rom_en) begin
        reads++;
        chk("rom_outstanding", 32'(reads - hs <= 4), 1);
        chk("rom_addr", rom_addr, 8'(sin));
        sin++;
      end
      if (stall_prev) chk("stall_stable", {out_valid, out_last, out_data}, {1'b1, stall_word});
      if (out_valid && out_ready) begin
        hs++;
        if (exp_q.size() == 0) fail_now("unexpected_word");
        else begin
          e = exp_q.pop_front();
          chk("word", {out_last, out_data}, e);
        end
      end
      stall_prev = out_valid && !out_ready;
      stall_word = {out_last, out_data};
      if (done) begin
        if (done_pend > 0) done_pend--;
        else fail_now("unexpected_done");
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_stream();
    for (int i = 0; i < 16; i++) exp_q.push_back({(i == 15), 8'(8'h10 + i)});
    done_pend++;
  endtask

  task automatic chk_reset(input string nm);
    chk({nm, "_rom_en"}, rom_en, 0);
    chk({nm, "_rom_addr"}, rom_addr, 0);
    chk({nm, "_valid"}, out_valid, 0);
    chk({nm, "_last"}, out_last, 0);
    chk({nm, "_data"}, out_data, 0);
    chk({nm, "_busy"}, busy, 0);
    chk({nm, "_done"}, done, 0);
  endtask

  // Runs until the expected done pulse is seen; s1/s2 are tick indices for stray starts.
  task automatic run(input bit rnd, input int s1, input int s2, input string nm);
    int t = 0;
    while (done_pend > 0 && t < 400) begin
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      start     = (t == s1 || t == s2);
      tick();
      t++;
    end
    start = 1'b0;
    out_ready = 1'b1;
    chk({nm, "_done_seen"}, done_pend, 0);
    chk({nm, "_drained"}, exp_q.size(), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int first_v, done_c, v_cnt, busy_bad, n, cnt, dcnt;
    logic [7:0] exp_addr [4];
    logic [7:0] exp_w4 [4];
    logic [7:0] got_addr [4];
    int na;

    rst = 1'b1; start = 1'b0; out_ready = 1'b1; s1_start = 1'b0; s4_start = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    @(negedge clk);
    chk_reset("reset");
    chk("reset_s1_valid", s1_valid, 0);
    chk("reset_s4_addr", s4_addr, 8'hFE);

    // Basic stream with fixed latency
    while (cyc < 4) tick();
    start = 1'b1;
    push_stream();
    tick();
    start = 1'b0;
    first_v = -1; done_c = -1; v_cnt = 0; busy_bad = 0;
    for (int c = 0; c < 25; c++) begin
      @(negedge clk);
      if (out_valid && first_v < 0) first_v = cyc;
      if (done && done_c < 0) done_c = cyc;
      if (out_valid && cyc >= 8 && cyc <= 23) v_cnt++;
      if (cyc >= 5 && cyc <= 23 && !busy) busy_bad++;
      if (cyc == 24) chk("busy_low_at_done", busy, 0);
    end
    chk("first_valid_cycle", first_v, 8);
    chk("done_cycle", done_c, 24);
    chk("valid_run", v_cnt, 16);
    chk("busy_window", busy_bad, 0);
    chk("basic_drained", exp_q.size(), 0);
    tick();

    // Backpressure
    start = 1'b1; push_stream(); tick(); start = 1'b0;
    run(1'b1, -1, -1, "backpressure");
    repeat (3) tick();

    // Starts during an active stream are ignored
    start = 1'b1; push_stream(); tick(); start = 1'b0;
    run(1'b0, 9, 14, "ignored_start");
    repeat (12) tick();
    chk("ignored_start_idle", busy, 0);
    chk("ignored_start_no_extra", exp_q.size(), 0);

    // Reset after word 6 handshakes
    start = 1'b1; push_stream(); tick(); start = 1'b0;
    n = 0;
    while (exp_q.size() > 9 && n < 200) begin tick(); n++; end
    chk("reset_wait_bound", 32'(n < 200), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
    done_pend = 0;
    @(negedge clk);
    chk_reset("midreset");
    repeat (6) tick();
    start = 1'b1; push_stream(); tick(); start = 1'b0;
    run(1'b0, -1, -1, "restart");

    // N_INPUTS=1
    s1_start = 1'b1; tick(); s1_start = 1'b0;
    cnt = 0; dcnt = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (s1_valid) begin
        cnt++;
        chk("n1_word", {s1_last, s1_data}, {1'b1, 8'hA5});
      end
      if (s1_done) dcnt++;
    end
    chk("n1_word_count", cnt, 1);
    chk("n1_done_count", dcnt, 1);

    // Address wrap with BASE_ADDR=FE, N_INPUTS=4
    exp_addr = '{8'hFE, 8'hFF, 8'h00, 8'h01};
    exp_w4   = '{8'hA4, 8'hA5, 8'h5A, 8'h5B};
    na = 0; cnt = 0; dcnt = 0;
    tick();
    s4_start = 1'b1; tick(); s4_start = 1'b0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (s4_rom_en) begin
        if (na < 4) got_addr[na] = s4_addr;
        na++;
      end
      if (s4_valid) begin
        if (cnt < 4) chk("wrap_word", {s4_last, s4_data}, {(cnt == 3), exp_w4[cnt]});
        cnt++;
      end
      if (s4_done) dcnt++;
    end
    chk("wrap_read_count", na, 4);
    for (int i = 0; i < 4; i++) if (i < na) chk("wrap_addr", got_addr[i], exp_addr[i]);
    chk("wrap_word_count", cnt, 4);
    chk("wrap_done_count", dcnt, 1);

    chk("final_queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
